// File: rtl/generic_pack.sv
// Shared definitions for the D5M capture-to-AXIS writer: FSM encoding and
// default geometry parameters.
package generic_pack;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_WIDTH  = 12;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_DROP       = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO whose head is presented combinationally; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module axis_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Zero the head while empty so the stream outputs read 0 in and after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/d5m_axis_video_writer.sv
// Converts a D5M-style frame/line-valid pixel stream into AXI4-Stream video
// (tuser = start of frame, tlast = end of line) through a small skid FIFO.
module d5m_axis_video_writer
    import generic_pack::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  ifval,
    input  logic                  ilval,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  m_axis_s2mm_tvalid,
    input  logic                  m_axis_s2mm_tready,
    output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic                  m_axis_s2mm_tuser,
    output logic                  m_axis_s2mm_tlast,
    output logic [CNT_WIDTH-1:0]  xCord,
    output logic [CNT_WIDTH-1:0]  yCord,
    output logic [15:0]           frame_count,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic [1:0]            dbg_state
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [FAW:0] ONE_ENTRY = 1;

    wr_state_e             state;
    wr_state_e             state_nxt;
    logic                  ifval_d;
    logic                  ilval_d;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  sof_pending;
    logic                  drop_drain;

    logic                  fval_rise;
    logic                  pix_valid;
    logic                  active;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  ovf_event;
    logic                  accept;
    logic                  empty_next;
    logic                  frame_done;

    logic [DATA_WIDTH+1:0] push_word;
    logic [DATA_WIDTH+1:0] head_word;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FAW:0]          fifo_count;

    assign fval_rise = ifval && !ifval_d;
    assign pix_valid = ifval && ilval;
    assign active    = (state == ST_ACTIVE);

    // The held pixel always leaves the next cycle: tlast=0 if another pixel of
    // the same line follows, tlast=1 when the line (or frame) has just ended.
    assign push_req  = active && hold_valid;
    assign push_word = {sof_pending, !pix_valid, hold_data};

    assign pop       = !fifo_empty && m_axis_s2mm_tready;
    assign ovf_event = push_req && fifo_full && !pop;
    assign push_ok   = push_req && !ovf_event;
    assign accept    = active && pix_valid && !ovf_event;

    assign empty_next = push_ok ? 1'b0 : (fifo_empty || (pop && fifo_count == ONE_ENTRY));
    // Only a tlast beat that drains the FIFO after the frame closed ends a frame;
    // the tail of a dropped frame is suppressed via drop_drain.
    assign frame_done = pop && head_word[DATA_WIDTH] && !ifval && empty_next && !drop_drain;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (!ifval)    state_nxt = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (fval_rise) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (ovf_event)   state_nxt = ST_DROP;
                else if (!ifval) state_nxt = ST_WAIT_FRAME;
            end
            ST_DROP:       if (!ifval)    state_nxt = ST_WAIT_FRAME;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            ifval_d     <= 1'b0;
            ilval_d     <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            sof_pending <= 1'b0;
            drop_drain  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            state      <= state_nxt;
            ifval_d    <= ifval;
            ilval_d    <= ilval;
            hold_valid <= accept;
            if (accept) hold_data <= idata;

            if (state == ST_WAIT_FRAME && fval_rise) sof_pending <= 1'b1;
            else if (push_ok)                        sof_pending <= 1'b0;

            if (ovf_event)       drop_drain <= 1'b1;
            else if (empty_next) drop_drain <= 1'b0;

            if (ovf_event)           overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;

            if (frame_done) frame_count <= frame_count + 1'b1;
        end
    end

    // hold_valid is low exactly on the first accepted pixel of a line.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            xCord <= '0;
            yCord <= '0;
        end else begin
            if (accept) xCord <= hold_valid ? xCord + 1'b1 : '0;
            if (state == ST_WAIT_FRAME && fval_rise)  yCord <= '0;
            else if (active && ilval_d && !ilval)     yCord <= yCord + 1'b1;
        end
    end

    axis_sync_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .push    (push_ok),
        .wr_data (push_word),
        .pop     (pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_axis_s2mm_tvalid = !fifo_empty;
    assign m_axis_s2mm_tuser  = head_word[DATA_WIDTH+1];
    assign m_axis_s2mm_tlast  = head_word[DATA_WIDTH];
    assign m_axis_s2mm_tdata  = head_word[DATA_WIDTH-1:0];
    assign dbg_state          = state;

endmodule

// File: doc/d5m_axis_video_writer.md
D5M_AXIS_VIDEO_WRITER -- requirements
Module: d5m_axis_video_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 24, is the pixel width of idata and m_axis_s2mm_tdata.
REQ-002 Parameter FIFO_DEPTH, default 16, is the number of skid FIFO entries, a power of 2.
REQ-003 Parameter CNT_WIDTH, default 12, is the width of the x/y counters.
REQ-004 The block SHALL have one clock and one reset: ACLK input 1 (sole clock); ARESETN input 1 (asynchronous assert, active-low).
REQ-005 ifval input 1: frame valid from the D5M-style pixel source.
REQ-006 ilval input 1: line valid; a pixel is present on every ACLK cycle in which ifval and ilval are both high.
REQ-007 idata input DATA_WIDTH: pixel data.
REQ-008 m_axis_s2mm_tvalid output 1; m_axis_s2mm_tready input 1; m_axis_s2mm_tdata output DATA_WIDTH.
REQ-009 m_axis_s2mm_tuser output 1 (start of frame); m_axis_s2mm_tlast output 1 (end of line).
REQ-010 xCord output CNT_WIDTH and yCord output CNT_WIDTH: position of the last accepted input pixel.
REQ-011 frame_count output 16: count of frames fully emitted.
REQ-012 overflow output 1: sticky flag, set when a pixel is lost.
REQ-013 clear_overflow input 1: synchronous clear of the overflow flag.

Function
REQ-014 The FSM SHALL have four states, with these transitions:
- IDLE -> WAIT_FRAME when ifval is low. This prevents joining a frame mid-way.
- WAIT_FRAME -> ACTIVE on a rising edge of ifval.
- ACTIVE -> WAIT_FRAME when ifval falls.
- ACTIVE -> DROP on FIFO overflow.
- DROP -> WAIT_FRAME when ifval falls.
REQ-015 Pixels SHALL be accepted only in ACTIVE. In IDLE, WAIT_FRAME and DROP, input pixels are discarded.
REQ-016 The block SHALL use a one-entry hold register:
- Each accepted pixel is held.
- The held pixel is pushed into the FIFO with tlast=0 on the next accepted pixel of the same line.
- The held pixel is pushed with tlast=1 on the cycle ilval falls.
REQ-017 The first pushed pixel after entering ACTIVE SHALL carry tuser=1; all other pushed pixels carry tuser=0.
REQ-018 Each FIFO entry SHALL store {tuser, tlast, tdata}. The AXIS outputs come directly from the FIFO head.
REQ-019 m_axis_s2mm_tvalid SHALL be high exactly when the FIFO is non-empty. An entry pops on tvalid and tready both high.
REQ-020 While tvalid is high and tready is low, tdata, tuser and tlast SHALL stay stable.
REQ-021 Minimum latency SHALL be 2 cycles from a pixel on idata to tvalid, with tready held high: 1 cycle hold register, 1 cycle FIFO.
REQ-022 A push and a pop in the same cycle SHALL leave the occupancy unchanged. This is legal when the FIFO is full.
REQ-023 Overflow SHALL be declared when a push occurs, the FIFO is full, and no pop occurs in that cycle. Then:
- the pixel is discarded;
- overflow is set to 1;
- the FSM enters DROP;
- the rest of the frame is discarded;
- entries already in the FIFO still drain.
REQ-024 If overflow setting and clear_overflow occur in the same cycle, the set SHALL win.
REQ-025 xCord SHALL reset to 0 at each ilval rising edge in ACTIVE and increment per accepted pixel. yCord SHALL reset to 0 at the frame start and increment at each ilval falling edge in ACTIVE. Both counters wrap modulo 2^CNT_WIDTH.
REQ-026 frame_count SHALL increment by 1, wrapping at 65535 to 0, when a pixel with tlast=1 pops and ifval is already low with the FIFO empty after the pop. Frames ended by DROP are not counted.
REQ-027 If ifval falls while a pixel is held and ilval is still high, the held pixel SHALL be pushed with tlast=1.
REQ-028 If ilval pulses high while ifval is low, the pulse SHALL be ignored and the counters stay unchanged.

Reset
REQ-029 While ARESETN is low, the block SHALL asynchronously force:
- FSM = IDLE;
- FIFO empty;
- hold register invalid;
- m_axis_s2mm_tvalid = 0, tuser = 0, tlast = 0, tdata = 0;
- xCord = 0, yCord = 0, frame_count = 0, overflow = 0.
REQ-030 Reset asserted mid-frame SHALL discard all buffered pixels. After release, the FSM waits in IDLE for ifval low.
REQ-031 Reset release SHALL take effect on the first ACLK rising edge after ARESETN goes high.

Structure
REQ-032 The FSM state enum and the default values of DATA_WIDTH and FIFO_DEPTH SHALL be defined in generic_pack.
REQ-033 The skid FIFO SHALL be a sub-module named axis_sync_fifo with parameters WIDTH = DATA_WIDTH+2 and DEPTH = FIFO_DEPTH, and ports push, pop, full, empty and count.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Frame of 4 lines x 8 pixels, tready=1 → 32 beats; tuser=1 on beat 0 only; tlast on beats 7, 15, 23 and 31; frame_count becomes 1; overflow stays 0.
- Same frame with tready toggling 1-cycle on / 1-cycle off, FIFO_DEPTH=16 → all 32 beats in order; tdata stable while stalled; overflow stays 0.
- tready=0 for a whole 4x8 frame with FIFO_DEPTH=16 → 16 entries kept, overflow=1, FSM in DROP, frame_count=0; a following good frame with tready=1 gives 32 beats and frame_count=1.
- Enable mid-frame: ifval already high at reset release → no output until the next full frame; tuser=1 on that frame's first beat.
- ARESETN pulsed low after 10 pixels of a line → tvalid drops asynchronously; no residual beats; the next frame is clean.
- Coordinates: pixel 5 of line 2 (0-based) accepted → xCord=5, yCord=2 on the following cycle.
